// File: rtl/sistemas_sincronos_pkg.sv
// Shared constants and helpers for the sistemas_sincronos registered bit selector.
package sistemas_sincronos_pkg;

  // Default number of selectable data bits.
  localparam int DATA_W_DEF = 4;

  // Default value loaded into the output flip-flop on reset.
  localparam logic RST_VAL_DEF = 1'b0;

  // Selector width needed to address data_w candidates; never narrower than 1 bit.
  function automatic int sel_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/sistemas_sincronos_mux.sv
// Purely combinational DATA_W:1 bit multiplexer.
// Selector values with no matching data bit (only possible when DATA_W is not a
// power of two) produce 0.
module sistemas_sincronos_mux
  import sistemas_sincronos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = sel_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              bit_out
);

  // Compare the selector against each legal index; unmatched codes fall through to 0.
  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    bit_out = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (sel == SEL_W'(i)) begin
        bit_out = data[i];
      end
    end
  end

endmodule

// File: rtl/sistemas_sincronos.sv
// Registered bit selector: o_q takes i_data[i_selector] on every rising i_clk edge.
// Optional feature: define SISTEMAS_SINCRONOS_SEL_REG_EN to insert a selector
// pipeline register (selector-to-output latency becomes 2 edges, data latency stays 1).
module sistemas_sincronos
  import sistemas_sincronos_pkg::*;
#(
  parameter int   DATA_W  = DATA_W_DEF,
  parameter int   SEL_W   = sel_w(DATA_W),
  parameter logic RST_VAL = RST_VAL_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_selector,
  output logic              o_q
);

  logic [SEL_W-1:0] mux_sel;
  logic             mux_bit;

`ifdef SISTEMAS_SINCRONOS_SEL_REG_EN
  logic [SEL_W-1:0] sel_q;

  // Pipeline the selector by one edge; cleared to index 0 while reset is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= i_selector;
    end
  end

  assign mux_sel = sel_q;
`else
  assign mux_sel = i_selector;
`endif

  sistemas_sincronos_mux #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data    (i_data),
    .sel     (mux_sel),
    .bit_out (mux_bit)
  );

  // Capture the selected bit every edge; reset forces RST_VAL immediately and wins over capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, avoiding simulation races.
    if (i_rst) begin
      o_q <= RST_VAL;
    end else begin
      o_q <= mux_bit;
    end
  end

endmodule

// File: tb/tb_sistemas_sincronos.sv
// Directed self-checking bench for sistemas_sincronos (default DATA_W=4 plus a DATA_W=3 instance).
// Expected values are hand-derived; the exhaustive sweep uses a bit-index reference model.
`timescale 1ns/1ps
module tb_sistemas_sincronos;

  logic       clk;
  logic       rst;
  logic [3:0] data;
  logic [1:0] sel;
  logic       q;

  logic [2:0] data3;
  logic [1:0] sel3;
  logic       q3;

  int n_tests = 0;
  int n_fail  = 0;

  sistemas_sincronos dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data),
    .i_selector (sel),
    .o_q        (q)
  );

  sistemas_sincronos #(.DATA_W(3)) dut3 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data3),
    .i_selector (sel3),
    .o_q        (q3)
  );

  // 100 ns period, rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected o_q after edges at 50/150/250/350 ns for the timed sequence.
`ifdef SISTEMAS_SINCRONOS_SEL_REG_EN
  localparam logic [3:0] EXP_SEQ = 4'b0011; // bits [0..3] = 1,1,0,0
`else
  localparam logic [3:0] EXP_SEQ = 4'b1001; // bits [0..3] = 1,0,0,1
`endif

  initial begin
    logic [3:0] dv;
    logic [3:0] exp_seq;
    exp_seq = EXP_SEQ;

    // Timed sequence: reset for 20 ns, selector stepped at 100/200/300 ns.
    rst   = 1'b1;
    data  = 4'b1001;
    sel   = 2'd0;
    data3 = 3'b000;
    sel3  = 2'd0;
    #10;
    check("reset_q", q, 1'b0);
    check("reset_q3", q3, 1'b0);
    #10 rst = 1'b0;
    #70 check("seq_edge50", q, exp_seq[0]);
    #10 sel = 2'd1;
    #90 check("seq_edge150", q, exp_seq[1]);
    #10 sel = 2'd2;
    #90 check("seq_edge250", q, exp_seq[2]);
    #10 sel = 2'd3;
    #90 check("seq_edge350", q, exp_seq[3]);

    // Out-of-range selector on the DATA_W=3 instance.
    @(negedge clk);
    data3 = 3'b111;
    sel3  = 2'd2;
    @(posedge clk);
    @(posedge clk); #1;
    check("w3_in_range", q3, 1'b1);
    @(negedge clk);
    sel3 = 2'd3;
    @(posedge clk);
    @(posedge clk); #1;
    check("w3_out_of_range", q3, 1'b0);

    // Data toggling mid-cycle with selector fixed at 2.
    @(negedge clk);
    sel  = 2'd2;
    data = 4'b0000;
    @(posedge clk);
    @(posedge clk); #1;
    check("tog_start", q, 1'b0);
    #24 data = 4'b0100;
    #10 check("tog_hold_low", q, 1'b0);
    @(posedge clk); #1;
    check("tog_edge_high", q, 1'b1);
    #24 data = 4'b0000;
    #10 check("tog_hold_high", q, 1'b1);
    @(posedge clk); #1;
    check("tog_edge_low", q, 1'b0);
    #20 data = 4'b0100;
    #20 data = 4'b0000;
    @(posedge clk); #1;
    check("tog_glitch_ignored", q, 1'b0);

    // Exhaustive sweep; one idle edge after each selector change lets the pipeline settle.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      @(posedge clk);
      for (int d = 0; d < 16; d++) begin
        @(negedge clk);
        dv   = 4'(d);
        data = dv;
        @(posedge clk); #1;
        check($sformatf("sweep_s%0d_d%0h", s, d), q, dv[s]);
      end
    end

    // Asynchronous reset mid-cycle, held across two edges, then released.
    @(negedge clk);
    data = 4'b1111;
    @(posedge clk); #1;
    check("rst_pre_high", q, 1'b1);
    #20 rst = 1'b1;
    #1 check("rst_immediate", q, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_edge1", q, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_edge2", q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_no_edge", q, 1'b0);
    @(posedge clk); #1;
    check("rst_release_edge", q, 1'b1);

    // Selector change 00->01 just before edge k with data 0001.
    @(negedge clk);
    data = 4'b0001;
    sel  = 2'd0;
    @(posedge clk);
    @(posedge clk); #1;
    check("selpipe_pre", q, 1'b1);
    @(negedge clk);
    sel = 2'd1;
    @(posedge clk); #1;
`ifdef SISTEMAS_SINCRONOS_SEL_REG_EN
    check("selpipe_edge_k", q, 1'b1);
`else
    check("selpipe_edge_k", q, 1'b0);
`endif
    @(posedge clk); #1;
    check("selpipe_edge_k1", q, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sistemas_sincronos.md
SISTEMAS_SINCRONOS -- requirements
Module: sistemas_sincronos

Interface
REQ-001 Parameter DATA_W, default 4: number of selectable data bits; legal range 2..16.
REQ-002 Parameter SEL_W, default $clog2(DATA_W): selector width, derived from DATA_W, not overridden by users.
REQ-003 Parameter RST_VAL, default 1'b0: value loaded into o_q on reset.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1 bit: reset; asynchronous and active-high.
REQ-006 Port i_data, input, DATA_W bits: data word; bit n is candidate n.
REQ-007 Port i_selector, input, SEL_W bits: unsigned index of the data bit to capture.
REQ-008 Port o_q, output, 1 bit: registered selected bit.

Function
REQ-009 Datapath: combinational DATA_W:1 mux selects i_data[i_selector]; a D flip-flop captures the mux output on each rising i_clk edge; o_q is the flip-flop output.
REQ-010 Latency: a change on i_data or i_selector appears on o_q only after the next rising i_clk edge; o_q never changes between edges, except on reset.
REQ-011 No enable: the flip-flop loads every cycle while i_rst is low.
REQ-012 Out-of-range selector (i_selector >= DATA_W, possible only when DATA_W is not a power of 2): the mux outputs 0 and o_q captures 0.
REQ-013 Inputs that change at the same instant as a rising edge: the value sampled is the pre-edge value; the design meets standard setup/hold.
REQ-014 X/Z on i_selector: the design is not required to resolve it; the verification bench must not drive X/Z on i_selector.

Reset
REQ-015 While i_rst is high: o_q = RST_VAL immediately, independent of i_clk; all internal registers are also held at reset.
REQ-016 On deassertion of i_rst: the first rising i_clk edge with i_rst low loads the mux output normally.
REQ-017 Reset asserted mid-operation: it overrides any capture in the same cycle.

Configuration
REQ-018 Macro SISTEMAS_SINCRONOS_SEL_REG_EN, when defined: adds a selector pipeline register. i_selector is registered on rising i_clk (reset value 0). The mux uses the registered selector, while i_data is still sampled directly. Selector-to-o_q latency is 2 edges; data-to-o_q latency stays 1 edge.
REQ-019 Without SISTEMAS_SINCRONOS_SEL_REG_EN: no selector register; behaviour exactly as REQ-009/REQ-010.

Structure
REQ-020 Shared package sistemas_sincronos_pkg holds: DATA_W default constant, RST_VAL default constant, and a function computing SEL_W.
REQ-021 One sub-module, sistemas_sincronos_mux: purely combinational DATA_W:1 bit mux including the out-of-range rule (REQ-012). The top level holds only the register(s) and reset logic.

Verification
REQ-022 Clock period 100 ns. i_rst=1 for first 20 ns, then 0. i_data=4'b1001. i_selector = 00, 01, 10, 11, changed at t=100, 200, 300 ns. Required o_q: 0 during reset; after the edges at t=50, 150, 250 and 350 ns, o_q = 1, 0, 0, 1 respectively.
REQ-023 i_selector=10, i_data toggles 4'b0000/4'b0100 mid-cycle -> o_q follows bit 2 only at rising edges, never between them.
REQ-024 o_q=1 (i_data=4'b1111), assert i_rst between edges -> o_q drops to RST_VAL immediately, without waiting for a clock edge. Hold i_rst across two edges -> o_q stays RST_VAL. Release i_rst -> o_q=1 after the next edge.
REQ-025 DATA_W=3, i_data=3'b111, i_selector=2'b11 -> o_q=0 after the next edge (out-of-range rule).
REQ-026 With SISTEMAS_SINCRONOS_SEL_REG_EN defined, i_data=4'b0001, i_selector changes 00->01 before edge k. Required o_q: still 1 after edge k (bit 0), 0 after edge k+1 (bit 1).
REQ-027 Exhaustive: all 16 i_data values x 4 i_selector values -> o_q = i_data[i_selector] one edge later, checked against a reference model.
